alu_iter_unit: RTL and testbench
================================

// Module: alu_iter_unit
// PURPOSE
//  Parametrised multi-cycle ALU for the MIPS datapath.
//  - Single-cycle logic/arith ops keep the existing 4-bit ALU_control encoding.
//  - Adds iterative signed multiply and unsigned divide.
//  - Valid/ready handshake on input and output so the pipeline can stall the EX stage.
//  - Produces the same 8-bit status byte layout used by the branch/exception logic.
// PARAMETERS
//  WIDTH     32  operand/result width (>=8, even)
//  MUL_STEP   1  multiplier bits retired per cycle (1 or 2); mul latency = WIDTH/MUL_STEP + 1
// PORTS
//  clk           in   1      rising-edge clock, single clock domain
//  rst           in   1      asynchronous, active-high reset
//  in_valid      in   1      operands/op valid
//  in_ready      out  1      unit can accept an op (high only in IDLE)
//  alu_control   in   4      op code (see BEHAVIOUR)
//  alu_op_1      in   WIDTH  operand A
//  alu_op_2      in   WIDTH  operand B
//  out_valid     out  1      result valid, held until out_ready
//  out_ready     in   1      consumer accepts result
//  alu_result    out  WIDTH  primary result (sum/logic/low product/quotient)
//  alu_result_hi out  WIDTH  high product / remainder; 0 for single-cycle ops
//  alu_status    out  8      [7]zero [6]signed ovf [5]carry [4]neg [3]misalign [2]rsvd=0 [1]illegal [0]div0
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, alu_result=0, alu_result_hi=0, alu_status=0.
//  Op codes: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt(signed), 1100 nor,
//   1000 mul(signed, 2*WIDTH product), 1001 divu; any other code -> illegal.
//  Accept: in_valid & in_ready on a rising edge; operands latched, in_ready drops next cycle.
//  FSM: IDLE -(single op)-> DONE (1 cycle); IDLE -(mul)-> MUL -> DONE;
//   IDLE -(divu)-> DIV -> DONE; DONE -(out_ready)-> IDLE.
//  Latency accept->out_valid: single op 1 cycle; mul WIDTH/MUL_STEP+1 cycles; div WIDTH+1 cycles.
//  DONE holds all outputs stable while out_ready=0; out_valid&out_ready returns to IDLE
//   with in_ready=1 next cycle (no same-cycle back-to-back accept).
//  Arithmetic on WIDTH+1 bits: carry=bit WIDTH of unsigned add (sub: borrow, i.e. A<B unsigned);
//   ovf=signed overflow for add/sub; for mul ovf=1 when the high half is not the sign-extension of the low half.
//  carry=0 and ovf=0 for all other ops.
//  neg=msb of alu_result (mul: msb of alu_result_hi); zero=all result bits (incl. hi for mul) are 0.
//  misalign=1 only for add when alu_result[1:0]!=0 (load/store address check).
//  slt: result = 1 or 0; status flags computed on that result.
//  divu by 0: quotient all ones, remainder=op_1, div0=1, same latency as normal div.
//  Illegal op: result=0, hi=0, illegal=1, zero=1, latency 1.
//  Reset asserted mid-op: abort immediately to reset values; no partial result is ever presented.
//  in_valid while busy: ignored; the producer must hold it (in_ready=0).
// CONFIGURATION
//  ALU_DIV_EN defined: divider datapath and DIV state built; 1001 behaves as above.
//  ALU_DIV_EN undefined: no divider logic; 1001 treated as illegal op (illegal=1, latency 1).
// TESTING
//  1 add 5+3, out_ready=1 -> result 8, status 8'h00, out_valid 1 cycle after accept.
//  2 add 7FFFFFFF+1 -> result 80000000, status ovf|neg|misalign... no: [1:0]=00 -> status 8'h50.
//  3 mul -3*7 (WIDTH=32) -> hi FFFFFFFF, lo FFFFFFEB, neg=1, ovf=0, out_valid 33 cycles after accept.
//  4 divu 100/7 -> q=14, r=2, status 8'h00; divu 9/0 -> q=FFFFFFFF, r=9, status 8'h11 (neg|div0).
//  5 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; release -> IDLE next cycle.
//  6 rst pulsed mid-mul at cycle 10 -> out_valid=0, in_ready=1, all outputs 0; next add completes normally.
//  7 (no ALU_DIV_EN) divu 100/7 -> result 0, status 8'h82.

Source files
------------

// File: rtl/alu_iter_unit_if.sv
// Handshake/operand/result bundle between the EX-stage pipeline and alu_iter_unit.
interface alu_iter_unit_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_control;
   logic [WIDTH-1:0] alu_op_1;
   logic [WIDTH-1:0] alu_op_2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] alu_result_hi;
   logic [7:0]       alu_status;

   modport master (
      output in_valid, alu_control, alu_op_1, alu_op_2, out_ready,
      input  in_ready, out_valid, alu_result, alu_result_hi, alu_status
   );

   modport slave (
      input  in_valid, alu_control, alu_op_1, alu_op_2, out_ready,
      output in_ready, out_valid, alu_result, alu_result_hi, alu_status
   );
endinterface

// File: rtl/alu_iter_unit.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith, iterative signed multiply and,
// when ALU_DIV_EN is defined, iterative unsigned divide (otherwise divu is illegal).
module alu_iter_unit #(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 1
) (
   input logic           clk,
   input logic           rst,
   alu_iter_unit_if.slave bus
);
   localparam int MUL_CYCLES = WIDTH / MUL_STEP;
   localparam int CW         = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
`ifdef ALU_DIV_EN
      DIV,
`endif
      DONE
   } state_t;

   state_t             state, state_next;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod, mcand, mul_next;
   logic [WIDTH-1:0]   mplier;
   logic               is_mul;
   logic               mul_last;

   logic [WIDTH:0]     sum_ext, diff_ext;
   logic [WIDTH-1:0]   single_res;
   logic [7:0]         single_status;
   logic               s_carry, s_ovf, s_mis, s_ill;

`ifdef ALU_DIV_EN
   logic               is_div;
   logic               div_last;
   logic [WIDTH-1:0]   rem, quo, divisor, rem_next, quo_next;
   logic [WIDTH:0]     div_trial;
   logic               div_ge;
`endif

   assign is_mul       = (bus.alu_control == 4'b1000);
   assign mul_last     = (cnt == CW'(MUL_CYCLES - 1));
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
`ifdef ALU_DIV_EN
   assign is_div   = (bus.alu_control == 4'b1001);
   assign div_last = (cnt == CW'(WIDTH - 1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               if (is_mul) state_next = MUL;
`ifdef ALU_DIV_EN
               else if (is_div) state_next = DIV;
`endif
               else state_next = DONE;
            end
         end
         MUL:  if (mul_last) state_next = DONE;
`ifdef ALU_DIV_EN
         DIV:  if (div_last) state_next = DONE;
`endif
         DONE: if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Single-cycle ops are evaluated straight from the bus and captured at accept.
   always_comb begin
      sum_ext    = {1'b0, bus.alu_op_1} + {1'b0, bus.alu_op_2};
      diff_ext   = {1'b0, bus.alu_op_1} - {1'b0, bus.alu_op_2};
      single_res = '0;
      s_carry    = 1'b0;
      s_ovf      = 1'b0;
      s_mis      = 1'b0;
      s_ill      = 1'b0;
      case (bus.alu_control)
         4'b0010: begin
            single_res = sum_ext[WIDTH-1:0];
            s_carry    = sum_ext[WIDTH];
            s_ovf      = (bus.alu_op_1[WIDTH-1] == bus.alu_op_2[WIDTH-1]) &&
                         (sum_ext[WIDTH-1] != bus.alu_op_1[WIDTH-1]);
            s_mis      = |sum_ext[1:0];
         end
         4'b0110: begin
            single_res = diff_ext[WIDTH-1:0];
            s_carry    = diff_ext[WIDTH];
            s_ovf      = (bus.alu_op_1[WIDTH-1] != bus.alu_op_2[WIDTH-1]) &&
                         (diff_ext[WIDTH-1] != bus.alu_op_1[WIDTH-1]);
         end
         4'b0000: single_res = bus.alu_op_1 & bus.alu_op_2;
         4'b0001: single_res = bus.alu_op_1 | bus.alu_op_2;
         4'b1100: single_res = ~(bus.alu_op_1 | bus.alu_op_2);
         4'b0111: single_res = {{(WIDTH-1){1'b0}},
                                ($signed(bus.alu_op_1) < $signed(bus.alu_op_2))};
         default: s_ill = 1'b1;
      endcase
      single_status = {(single_res == '0), s_ovf, s_carry, single_res[WIDTH-1],
                       s_mis, 1'b0, s_ill, 1'b0};
   end

   // Shift-add multiply; the multiplier's msb carries negative weight, giving a signed product.
   always_comb begin
      mul_next = prod;
      for (int j = 0; j < MUL_STEP; j++) begin
         if (mplier[j]) begin
            if (mul_last && (j == MUL_STEP - 1)) mul_next = mul_next - (mcand << j);
            else                                  mul_next = mul_next + (mcand << j);
         end
      end
   end

`ifdef ALU_DIV_EN
   // Restoring division; a zero divisor naturally yields all-ones quotient and rem = dividend.
   always_comb begin
      div_trial = {rem, quo[WIDTH-1]};
      div_ge    = (div_trial >= {1'b0, divisor});
      rem_next  = div_ge ? (div_trial[WIDTH-1:0] - divisor) : div_trial[WIDTH-1:0];
      quo_next  = {quo[WIDTH-2:0], div_ge};
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt               <= '0;
         prod              <= '0;
         mcand             <= '0;
         mplier            <= '0;
         bus.alu_result    <= '0;
         bus.alu_result_hi <= '0;
         bus.alu_status    <= '0;
`ifdef ALU_DIV_EN
         rem               <= '0;
         quo               <= '0;
         divisor           <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  cnt <= '0;
                  if (is_mul) begin
                     prod   <= '0;
                     mcand  <= {{WIDTH{bus.alu_op_1[WIDTH-1]}}, bus.alu_op_1};
                     mplier <= bus.alu_op_2;
                  end
`ifdef ALU_DIV_EN
                  else if (is_div) begin
                     rem     <= '0;
                     quo     <= bus.alu_op_1;
                     divisor <= bus.alu_op_2;
                  end
`endif
                  else begin
                     bus.alu_result    <= single_res;
                     bus.alu_result_hi <= '0;
                     bus.alu_status    <= single_status;
                  end
               end
            end
            MUL: begin
               prod   <= mul_next;
               mcand  <= mcand << MUL_STEP;
               mplier <= mplier >> MUL_STEP;
               cnt    <= cnt + 1'b1;
               if (mul_last) begin
                  bus.alu_result    <= mul_next[WIDTH-1:0];
                  bus.alu_result_hi <= mul_next[2*WIDTH-1:WIDTH];
                  bus.alu_status    <= {(mul_next == '0),
                                        (mul_next[2*WIDTH-1:WIDTH] != {WIDTH{mul_next[WIDTH-1]}}),
                                        1'b0, mul_next[2*WIDTH-1], 4'b0000};
               end
            end
`ifdef ALU_DIV_EN
            DIV: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt + 1'b1;
               if (div_last) begin
                  bus.alu_result    <= quo_next;
                  bus.alu_result_hi <= rem_next;
                  bus.alu_status    <= {(quo_next == '0), 2'b00, quo_next[WIDTH-1],
                                        3'b000, (divisor == '0)};
               end
            end
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_iter_unit.sv
// Randomized self-checking bench for alu_iter_unit against an arithmetic reference model.
module tb_alu_iter_unit;
   localparam int WIDTH    = 32;
   localparam int MUL_STEP = 1;
   localparam longint MAXI = 2147483647;
   localparam longint MINI = -MAXI - 1;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] lastRes, lastHi;
   logic [7:0]  lastStatus;

   alu_iter_unit_if #(.WIDTH(WIDTH)) bus ();

   alu_iter_unit #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference behaviour from the op definitions using plain wide arithmetic.
   function automatic void computeExpected(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, output logic [31:0] r,
                                           output logic [31:0] h, output logic [7:0] st,
                                           output int lat);
      longint sa, sb, s;
      logic [63:0] ua, ub, p;
      logic ovf, cry, mis, ill, dz, z, n;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      r = '0; h = '0; s = 0; p = '0;
      ovf = 0; cry = 0; mis = 0; ill = 0; dz = 0;
      lat = 1;
      case (op)
         4'h2: begin
            r = a + b; s = sa + sb;
            cry = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
            ovf = (s > MAXI) || (s < MINI);
            mis = (r[1:0] != 2'b00);
         end
         4'h6: begin
            r = a - b; s = sa - sb;
            cry = (ua < ub);
            ovf = (s > MAXI) || (s < MINI);
         end
         4'h0: r = a & b;
         4'h1: r = a | b;
         4'hC: r = ~(a | b);
         4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
         4'h8: begin
            s = sa * sb;
            p = s;
            r = p[31:0];
            h = p[63:32];
            ovf = (s > MAXI) || (s < MINI);
            lat = WIDTH / MUL_STEP + 1;
         end
`ifdef ALU_DIV_EN
         4'h9: begin
            if (b == 0) begin
               r = 32'hFFFF_FFFF; h = a; dz = 1;
            end else begin
               r = a / b; h = a % b;
            end
            lat = WIDTH + 1;
         end
`endif
         default: ill = 1;
      endcase
      if (op == 4'h8) begin
         z = (s == 0);
         n = (s < 0);
      end else begin
         z = (r == 0);
         n = r[31];
      end
      st = {z, ovf, cry, n, mis, 1'b0, ill, dz};
   endfunction

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int hold);
      logic [31:0] er, eh;
      logic [7:0]  es;
      int          el, cycles, w;
      logic [63:0] snap;
      computeExpected(op, a, b, er, eh, es, el);
      w = 0;
      while (!bus.in_ready && w < 100) begin
         @(posedge clk); #1; w++;
      end
      checkOutput("in_ready_idle", bus.in_ready, 1);
      bus.in_valid    = 1'b1;
      bus.alu_control = op;
      bus.alu_op_1    = a;
      bus.alu_op_2    = b;
      bus.out_ready   = (hold == 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.alu_op_1 = $urandom;
      bus.alu_op_2 = $urandom;
      cycles = 0;
      while (!bus.out_valid && cycles < 200) begin
         @(posedge clk); #1; cycles++;
      end
      checkOutput($sformatf("latency op%0h", op), cycles + 1, el);
      checkOutput($sformatf("result op%0h %h,%h", op, a, b), bus.alu_result, er);
      checkOutput($sformatf("hi op%0h %h,%h", op, a, b), bus.alu_result_hi, eh);
      checkOutput($sformatf("status op%0h %h,%h", op, a, b), bus.alu_status, es);
      checkOutput("busy_in_ready", bus.in_ready, 0);
      lastRes = bus.alu_result;
      lastHi = bus.alu_result_hi;
      lastStatus = bus.alu_status;
      if (hold > 0) begin
         for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            snap = {bus.out_valid, bus.in_ready, bus.alu_status, bus.alu_result};
            checkOutput("hold_stable", snap, {1'b1, 1'b0, es, er});
            checkOutput("hold_hi", bus.alu_result_hi, eh);
         end
         bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      checkOutput("release_idle", {bus.out_valid, bus.in_ready}, 2'b01);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h7FFF_FFFF;
         4: return 32'h8000_0000;
         5: return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   logic [3:0] opTable [12];

   initial begin
      opTable = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'hC, 4'h8, 4'h9, 4'h3, 4'hF, 4'h8, 4'h9};
      rst             = 1'b1;
      bus.in_valid    = 1'b0;
      bus.alu_control = 4'h0;
      bus.alu_op_1    = '0;
      bus.alu_op_2    = '0;
      bus.out_ready   = 1'b1;
      #12;
      checkOutput("reset_handshake", {bus.out_valid, bus.in_ready}, 2'b01);
      checkOutput("reset_result", bus.alu_result, 0);
      checkOutput("reset_hi", bus.alu_result_hi, 0);
      checkOutput("reset_status", bus.alu_status, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      applyStimulus(4'h2, 32'd5, 32'd3, 0);
      checkOutput("t1_add", {lastStatus, lastRes}, {8'h00, 32'd8});
      applyStimulus(4'h2, 32'h7FFF_FFFF, 32'd1, 0);
      checkOutput("t2_add_ovf", {lastStatus, lastRes}, {8'h50, 32'h8000_0000});
      applyStimulus(4'h8, 32'hFFFF_FFFD, 32'd7, 0);
      checkOutput("t3_mul", {lastHi, lastRes}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
      applyStimulus(4'h9, 32'd100, 32'd7, 0);
`ifdef ALU_DIV_EN
      checkOutput("t4_div", {lastStatus, lastHi, lastRes}, {8'h00, 32'd2, 32'd14});
      applyStimulus(4'h9, 32'd9, 32'd0, 0);
      checkOutput("t4_div0", {lastStatus, lastHi, lastRes}, {8'h11, 32'd9, 32'hFFFF_FFFF});
`else
      checkOutput("t7_div_illegal", {lastStatus, lastRes}, {8'h82, 32'd0});
`endif
      applyStimulus(4'h6, 32'd3, 32'd5, 5);
      applyStimulus(4'h8, 32'h8000_0000, 32'h8000_0000, 3);

      // Reset pulsed partway through a multiply must abort without presenting a result.
      bus.in_valid    = 1'b1;
      bus.alu_control = 4'h8;
      bus.alu_op_1    = 32'd1234;
      bus.alu_op_2    = 32'd5678;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midrst_handshake", {bus.out_valid, bus.in_ready}, 2'b01);
      checkOutput("midrst_outputs", {bus.alu_status, bus.alu_result_hi, bus.alu_result}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      applyStimulus(4'h2, 32'd100, 32'd28, 0);

      for (int i = 0; i < 40; i++) begin
         applyStimulus(opTable[$urandom_range(0, 11)], pickOperand(), pickOperand(),
                       int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
